// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared loader state encodings and instruction store geometry
package core_pkg;

  localparam int DEPTH  = 32;
  localparam int ADDR_W = 5;
  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    LD_IDLE = 2'd0,
    LD_LOAD = 2'd1,
    LD_DONE = 2'd2
  } ld_state_t;

endpackage

// File: rtl/byte_packer.sv
// rtl/byte_packer.sv - packs a big-endian byte stream into 32-bit words
//
// Ports:
//   clk          in  clock, rising edge
//   reset        in  asynchronous active-low reset
//   i_clear      in  restart packing at byte 0 of a word
//   i_hs         in  a byte is transferred this cycle
//   i_byte       in  transferred byte
//   o_word_valid out 4th byte of a word is being transferred this cycle
//   o_word       out packed word, valid with o_word_valid
module byte_packer
  import core_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              i_clear,
  input  logic              i_hs,
  input  logic [7:0]        i_byte,
  output logic              o_word_valid,
  output logic [WORD_W-1:0] o_word
);

  logic [23:0] r_asm;
  logic [1:0]  r_idx;

  // The 4th byte is not stored: the word is formed from the three held bytes
  // plus the byte on the bus, so it can be written on the same edge.
  assign o_word_valid = i_hs && (r_idx == 2'd3);
  assign o_word       = {r_asm, i_byte};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_asm <= '0;
      r_idx <= '0;
    end else if (i_clear) begin
      r_asm <= '0;
      r_idx <= '0;
    end else if (i_hs) begin
      r_asm <= {r_asm[15:0], i_byte};
      r_idx <= r_idx + 2'd1;
    end
  end

endmodule

// File: rtl/instr_mem_loader.sv
// rtl/instr_mem_loader.sv - loads a program byte stream into the instruction store and serves fetches
//
// Ports:
//   clk          in  clock, rising edge
//   reset        in  asynchronous active-low reset
//   load_start   in  1-cycle pulse: begin loading load_len words
//   load_len     in  words to load, legal 1..32
//   byte_in      in  program byte
//   byte_valid   in  byte_in valid
//   byte_ready   out loader accepts a byte this cycle
//   fetch_addr   in  byte address from the PC
//   instr_out    out instruction at fetch_addr (0 unless the program is resident)
//   cpu_hold     out keep core in reset / stalled
//   load_done    out program resident, core released
//   load_err     out 1-cycle pulse: illegal load_len on load_start
//   words_loaded out words written since the last accepted load_start
module instr_mem_loader
  import core_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load_start,
  input  logic [5:0]        load_len,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  input  logic [31:0]       fetch_addr,
  output logic [WORD_W-1:0] instr_out,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_err,
  output logic [5:0]        words_loaded
);

  ld_state_t         r_state;
  ld_state_t         w_next;
  logic [5:0]        r_len;
  logic [5:0]        r_words;
  logic              r_byte_ready;
  logic              r_load_err;
  logic [WORD_W-1:0] r_mem [DEPTH];

  logic              w_legal;
  logic              w_accept;
  logic              w_illegal;
  logic              w_hs;
  logic              w_word_valid;
  logic [WORD_W-1:0] w_word;
  logic [5:0]        w_words_inc;
  logic [ADDR_W-1:0] w_fetch_idx;
  logic              w_unused_addr_bits;

  assign w_legal     = (load_len != 6'd0) && (load_len <= 6'(DEPTH));
  // load_start is ignored while a load is in progress.
  assign w_accept    = load_start && w_legal  && (r_state != LD_LOAD);
  assign w_illegal   = load_start && !w_legal && (r_state != LD_LOAD);
  assign w_hs        = byte_valid && r_byte_ready;
  assign w_words_inc = r_words + 6'd1;

  byte_packer u_packer (
    .clk          (clk),
    .reset        (reset),
    .i_clear      (w_accept),
    .i_hs         (w_hs),
    .i_byte       (byte_in),
    .o_word_valid (w_word_valid),
    .o_word       (w_word)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      LD_IDLE: if (w_accept) w_next = LD_LOAD;
      // Leave LOAD on the same edge that writes the last word so that
      // byte_ready is already low in the following cycle.
      LD_LOAD: if (w_word_valid && (w_words_inc == r_len)) w_next = LD_DONE;
      LD_DONE: if (w_accept) w_next = LD_LOAD;
      default: w_next = LD_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= LD_IDLE;
      r_len        <= '0;
      r_words      <= '0;
      r_byte_ready <= 1'b0;
      r_load_err   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      r_state      <= w_next;
      r_byte_ready <= (w_next == LD_LOAD);
      r_load_err   <= w_illegal;
      if (w_accept) begin
        r_len   <= load_len;
        r_words <= '0;
      end else if (w_word_valid) begin
        r_words <= w_words_inc;
      end
      if (w_word_valid) r_mem[r_words[ADDR_W-1:0]] <= w_word;
    end
  end

  // Byte offset and upper address bits are ignored: fetches wrap every 128 bytes.
  assign w_fetch_idx        = fetch_addr[ADDR_W+1:2];
  assign w_unused_addr_bits = ^{fetch_addr[31:ADDR_W+2], fetch_addr[1:0]};

  assign instr_out    = (r_state == LD_DONE) ? r_mem[w_fetch_idx] : '0;
  assign byte_ready   = r_byte_ready;
  assign cpu_hold     = (r_state != LD_DONE);
  assign load_done    = (r_state == LD_DONE);
  assign load_err     = r_load_err;
  assign words_loaded = r_words;

endmodule
